// File: rtl/entrada_painel.sv
// Input conditioning for the mini CPU core: synchronizes and debounces the three
// active-low pushbuttons and captures the switch word on each send release.
module entrada_painel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int SW_WIDTH        = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                botao_inicio,
    input  logic                botao_send,
    input  logic                botao_clear,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                instr_ack,
    output logic                pulso_inicio,
    output logic                pulso_send,
    output logic                pulso_clear,
    output logic                nivel_inicio,
    output logic                nivel_send,
    output logic                nivel_clear,
    output logic [SW_WIDTH-1:0] instr_out,
    output logic                instr_valid,
    output logic                instr_overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRA_PRESS,
        PRESSIONADO,
        FILTRA_SOLTA
    } estado_t;

    // Button index 2 = inicio, 1 = send, 0 = clear.
    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_btn [3];
    logic [SW_WIDTH-1:0]    sync_sw  [SYNC_STAGES];
    estado_t                estado   [3];
    logic [CW-1:0]          cnt      [3];
    logic [2:0]             amostra;
    logic [2:0]             solta;
    logic [2:0]             nivel;
    logic [2:0]             pulso;

    assign raw = {botao_inicio, botao_send, botao_clear};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                sync_btn[i] <= '1;
            end
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_sw[k] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_btn[i] <= {sync_btn[i][SYNC_STAGES-2:0], raw[i]};
            end
            sync_sw[0] <= switches;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_sw[k] <= sync_sw[k-1];
            end
        end
    end

    // A release is confirmed on the last consecutive high sample of FILTRA_SOLTA.
    always_comb begin
        amostra = '0;
        solta   = '0;
        for (int i = 0; i < 3; i++) begin
            amostra[i] = sync_btn[i][SYNC_STAGES-1];
            solta[i]   = (estado[i] == FILTRA_SOLTA) && amostra[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                estado[i] <= OCIOSO;
                cnt[i]    <= '0;
            end
            nivel <= '0;
            pulso <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pulso[i] <= solta[i];
                nivel[i] <= (estado[i] == PRESSIONADO) || (estado[i] == FILTRA_SOLTA);
                case (estado[i])
                    OCIOSO: begin
                        if (!amostra[i]) begin
                            estado[i] <= FILTRA_PRESS;
                            cnt[i]    <= CW'(1);
                        end
                    end
                    FILTRA_PRESS: begin
                        if (amostra[i]) begin
                            estado[i] <= OCIOSO;
                            cnt[i]    <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            estado[i] <= PRESSIONADO;
                            cnt[i]    <= '0;
                            nivel[i]  <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    PRESSIONADO: begin
                        if (amostra[i]) begin
                            estado[i] <= FILTRA_SOLTA;
                            cnt[i]    <= CW'(1);
                        end
                    end
                    FILTRA_SOLTA: begin
                        if (!amostra[i]) begin
                            estado[i] <= PRESSIONADO;
                            cnt[i]    <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            estado[i] <= OCIOSO;
                            cnt[i]    <= '0;
                            nivel[i]  <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    default: begin
                        estado[i] <= OCIOSO;
                        cnt[i]    <= '0;
                    end
                endcase
            end
        end
    end

    // Capture shares the edge that raises pulso_send; an ack on that edge frees the slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_out     <= '0;
            instr_valid   <= 1'b0;
            instr_overrun <= 1'b0;
        end else if (solta[1]) begin
            if (!instr_valid || instr_ack) begin
                instr_out     <= sync_sw[SYNC_STAGES-1];
                instr_valid   <= 1'b1;
                instr_overrun <= 1'b0;
            end else begin
                instr_overrun <= 1'b1;
            end
        end else if (instr_valid && instr_ack) begin
            instr_valid   <= 1'b0;
            instr_overrun <= 1'b0;
        end
    end

    assign pulso_inicio = pulso[2];
    assign pulso_send   = pulso[1];
    assign pulso_clear  = pulso[0];
    assign nivel_inicio = nivel[2];
    assign nivel_send   = nivel[1];
    assign nivel_clear  = nivel[0];

endmodule

// File: tb/tb_entrada_painel.sv
// Scoreboard bench for entrada_painel with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// stimulus queues expected pulse events, a monitor pops them when pulses appear.
module tb_entrada_painel;

    localparam int SWW = 18;
    localparam int LAT = 6;

    logic           clk;
    logic           reset;
    logic           botao_inicio, botao_send, botao_clear;
    logic [SWW-1:0] switches;
    logic           instr_ack;
    logic           pulso_inicio, pulso_send, pulso_clear;
    logic           nivel_inicio, nivel_send, nivel_clear;
    logic [SWW-1:0] instr_out;
    logic           instr_valid, instr_overrun;

    typedef struct {
        logic [2:0]     pulses;
        logic [SWW-1:0] instr;
        logic           valid;
        logic           ovr;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    entrada_painel #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2),
        .SW_WIDTH(SWW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .botao_inicio(botao_inicio),
        .botao_send(botao_send),
        .botao_clear(botao_clear),
        .switches(switches),
        .instr_ack(instr_ack),
        .pulso_inicio(pulso_inicio),
        .pulso_send(pulso_send),
        .pulso_clear(pulso_clear),
        .nivel_inicio(nivel_inicio),
        .nivel_send(nivel_send),
        .nivel_clear(nivel_clear),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .instr_overrun(instr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: every edge that shows a pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if ({pulso_inicio, pulso_send, pulso_clear} != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, pulso_inicio, pulso_send, pulso_clear}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulses", {29'd0, pulso_inicio, pulso_send, pulso_clear}, {29'd0, e.pulses});
                check("pulse_cycle", cyc, e.cyc);
                check("instr_out", {14'd0, instr_out}, {14'd0, e.instr});
                check("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
                check("instr_overrun", {31'd0, instr_overrun}, {31'd0, e.ovr});
            end
        end
    end

    task automatic set_buttons(input logic [2:0] low_mask);
        botao_inicio = ~low_mask[2];
        botao_send   = ~low_mask[1];
        botao_clear  = ~low_mask[0];
    endtask

    task automatic press_hold(input logic [2:0] m);
        set_buttons(m);
        repeat (10) @(negedge clk);
    endtask

    task automatic release_expect(input logic [2:0] m, input logic [SWW-1:0] instr,
                                  input logic valid, input logic ovr);
        exp_t e;
        e.pulses = m;
        e.instr  = instr;
        e.valid  = valid;
        e.ovr    = ovr;
        e.cyc    = cyc + LAT;
        exp_q.push_back(e);
        set_buttons(3'b000);
    endtask

    task automatic ack_one_cycle();
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulses"}, {29'd0, pulso_inicio, pulso_send, pulso_clear}, 32'd0);
        check({tag, "_nivel"}, {29'd0, nivel_inicio, nivel_send, nivel_clear}, 32'd0);
        check({tag, "_instr_out"}, {14'd0, instr_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, instr_overrun}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        set_buttons(3'b000);
        switches  = '0;
        instr_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // 1: clean send press/release captures the switches
        switches = 18'h2A5C3;
        press_hold(3'b010);
        check("t1_nivel_send", {31'd0, nivel_send}, 32'd1);
        release_expect(3'b010, 18'h2A5C3, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        ack_one_cycle();
        check("t1_valid_after_ack", {31'd0, instr_valid}, 32'd0);

        // 2: bouncing start button never qualifies
        for (int k = 0; k < 3; k++) begin
            botao_inicio = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("t2_nivel_inicio", {31'd0, nivel_inicio}, 32'd0);
            end
            botao_inicio = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check("t2_nivel_inicio", {31'd0, nivel_inicio}, 32'd0);
            end
        end
        repeat (10) @(negedge clk);
        check("t2_nivel_inicio_end", {31'd0, nivel_inicio}, 32'd0);

        // 3: second send while a word is pending raises overrun
        switches = 18'h15A5A;
        press_hold(3'b010);
        release_expect(3'b010, 18'h15A5A, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        switches = 18'h00001;
        press_hold(3'b010);
        release_expect(3'b010, 18'h15A5A, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_instr_kept", {14'd0, instr_out}, {14'd0, 18'h15A5A});
        ack_one_cycle();
        check("t3_valid_after_ack", {31'd0, instr_valid}, 32'd0);
        check("t3_overrun_after_ack", {31'd0, instr_overrun}, 32'd0);

        // 4: ack on the same edge as a new send pulse
        switches = 18'h12345;
        press_hold(3'b010);
        release_expect(3'b010, 18'h12345, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        switches = 18'h3FFFF;
        press_hold(3'b010);
        release_expect(3'b010, 18'h3FFFF, 1'b1, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        ack_one_cycle();
        repeat (3) @(negedge clk);
        check("t4_valid_held", {31'd0, instr_valid}, 32'd1);
        check("t4_instr_out", {14'd0, instr_out}, {14'd0, 18'h3FFFF});
        ack_one_cycle();

        // 5: simultaneous release of all three buttons
        switches = 18'h0ABCD;
        press_hold(3'b111);
        check("t5_nivel_all", {29'd0, nivel_inicio, nivel_send, nivel_clear}, 32'd7);
        release_expect(3'b111, 18'h0ABCD, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // 6: reset two cycles into the clear release filter
        press_hold(3'b001);
        set_buttons(3'b000);
        repeat (4) @(negedge clk);
        check("t6_nivel_clear_pre", {31'd0, nivel_clear}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_nivel_clear_post", {31'd0, nivel_clear}, 32'd0);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
